// File: rtl/module_operand_ctrl_if.sv
// Keypad/datapath/display bundle of the operand sequencer.
// The master side drives the keypad and res_done. The slave side is the sequencer.
interface module_operand_ctrl_if #(
   parameter int N = 4
);
   logic         key_valid;
   logic [3:0]   key_code;
   logic         res_done;
   logic [N-1:0] tens_d;
   logic [N-1:0] units_d;
   logic         a_tens_en;
   logic         a_units_en;
   logic         b_tens_en;
   logic         b_units_en;
   logic         clr_regs;
   logic         op_start;
   logic [1:0]   disp_sel;
   logic         busy;
   logic         err;

   modport master (
      output key_valid, key_code, res_done,
      input  tens_d, units_d, a_tens_en, a_units_en, b_tens_en, b_units_en,
             clr_regs, op_start, disp_sel, busy, err
   );

   modport slave (
      input  key_valid, key_code, res_done,
      output tens_d, units_d, a_tens_en, a_units_en, b_tens_en, b_units_en,
             clr_regs, op_start, disp_sel, busy, err
   );
endinterface

// File: rtl/module_operand_ctrl.sv
// Operand entry sequencer: shifts keypad digits into operand A/B, starts the
// datapath, times out the result wait and selects the display source.
module module_operand_ctrl #(
   parameter int N       = 4,
   parameter int TIMEOUT = 1024
) (
   input logic                  clk,
   input logic                  rst,
   module_operand_ctrl_if.slave bus
);
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      ENTRY_A = 3'd0,
      ENTRY_B = 3'd1,
      START   = 3'd2,
      WAIT    = 3'd3,
      SHOW    = 3'd4,
      ERR     = 3'd5
   } state_t;

   state_t          state_r, state_s;
   logic [1:0]      cnt_r, cnt_s;
   logic [N-1:0]    shadow_r, shadow_s;
   logic [TW-1:0]   timer_r, timer_s;
   logic [N-1:0]    tens_d_r, tens_d_s;
   logic [N-1:0]    units_d_r, units_d_s;
   logic            load_a_r, load_a_s;
   logic            load_b_r, load_b_s;
   logic            clr_r, clr_s;
   logic            start_r, start_s;
   logic [1:0]      disp_r, disp_s;
   logic            busy_r, busy_s;
   logic            err_r, err_s;
   logic            is_digit_s, is_enter_s, is_clear_s;
   logic [N-1:0]    key_s;

   function automatic logic digit_code(input logic [3:0] code);
      return (code <= 4'd9);
   endfunction

   // Key decode; unlisted codes fall through every branch below with no effect.
   always_comb begin
      is_digit_s = bus.key_valid && digit_code(bus.key_code);
      is_enter_s = bus.key_valid && (bus.key_code == 4'hA);
      is_clear_s = bus.key_valid && (bus.key_code == 4'hC);
      key_s      = N'(bus.key_code);
   end

   // Next-state and next-output computation for the entry FSM.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      shadow_s  = shadow_r;
      timer_s   = timer_r;
      tens_d_s  = tens_d_r;
      units_d_s = units_d_r;
      load_a_s  = 1'b0;
      load_b_s  = 1'b0;
      clr_s     = 1'b0;
      start_s   = 1'b0;
      disp_s    = disp_r;
      busy_s    = busy_r;
      err_s     = err_r;

      if (is_clear_s) begin
         state_s  = ENTRY_A;
         cnt_s    = 2'd0;
         shadow_s = {N{1'b0}};
         clr_s    = 1'b1;
         disp_s   = 2'b00;
         busy_s   = 1'b0;
         err_s    = 1'b0;
      end else begin
         case (state_r)
            ENTRY_A, ENTRY_B: begin
               if (is_digit_s && (cnt_r != 2'd2)) begin
                  // Shift-left entry: the previous digit moves up into tens.
                  tens_d_s  = (cnt_r == 2'd0) ? {N{1'b0}} : shadow_r;
                  units_d_s = key_s;
                  shadow_s  = key_s;
                  cnt_s     = cnt_r + 2'd1;
                  load_a_s  = (state_r == ENTRY_A);
                  load_b_s  = (state_r == ENTRY_B);
               end else if (is_enter_s && (cnt_r != 2'd0)) begin
                  cnt_s = 2'd0;
                  if (state_r == ENTRY_A) begin
                     state_s = ENTRY_B;
                     disp_s  = 2'b01;
                  end else begin
                     state_s = START;
                     start_s = 1'b1;
                     busy_s  = 1'b1;
                     timer_s = {TW{1'b0}};
                  end
               end else begin
                  state_s = state_r;
               end
            end
            START: begin
               // timer counts cycles since op_start rose.
               state_s = WAIT;
               timer_s = timer_r + TW'(1);
            end
            WAIT: begin
               if (bus.res_done) begin
                  state_s = SHOW;
                  disp_s  = 2'b10;
                  busy_s  = 1'b0;
               end else if (timer_r == TW'(TIMEOUT - 1)) begin
                  state_s = ERR;
                  disp_s  = 2'b11;
                  busy_s  = 1'b0;
                  err_s   = 1'b1;
               end else begin
                  timer_s = timer_r + TW'(1);
               end
            end
            SHOW, ERR: begin
               if (is_digit_s || is_enter_s) begin
                  state_s  = ENTRY_A;
                  cnt_s    = 2'd0;
                  shadow_s = {N{1'b0}};
                  clr_s    = 1'b1;
                  disp_s   = 2'b00;
                  err_s    = 1'b0;
               end else begin
                  state_s = state_r;
               end
            end
            default: begin
               state_s = ENTRY_A;
               cnt_s   = 2'd0;
               busy_s  = 1'b0;
               disp_s  = 2'b00;
            end
         endcase
      end
   end

   // State and registered-output update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ENTRY_A;
         cnt_r     <= 2'd0;
         shadow_r  <= {N{1'b0}};
         timer_r   <= {TW{1'b0}};
         tens_d_r  <= {N{1'b0}};
         units_d_r <= {N{1'b0}};
         load_a_r  <= 1'b0;
         load_b_r  <= 1'b0;
         clr_r     <= 1'b0;
         start_r   <= 1'b0;
         disp_r    <= 2'b00;
         busy_r    <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         shadow_r  <= shadow_s;
         timer_r   <= timer_s;
         tens_d_r  <= tens_d_s;
         units_d_r <= units_d_s;
         load_a_r  <= load_a_s;
         load_b_r  <= load_b_s;
         clr_r     <= clr_s;
         start_r   <= start_s;
         disp_r    <= disp_s;
         busy_r    <= busy_s;
         err_r     <= err_s;
      end
   end

   assign bus.tens_d     = tens_d_r;
   assign bus.units_d    = units_d_r;
   assign bus.a_tens_en  = load_a_r;
   assign bus.a_units_en = load_a_r;
   assign bus.b_tens_en  = load_b_r;
   assign bus.b_units_en = load_b_r;
   assign bus.clr_regs   = clr_r;
   assign bus.op_start   = start_r;
   assign bus.disp_sel   = disp_r;
   assign bus.busy       = busy_r;
   assign bus.err        = err_r;
endmodule

// File: tb/tb_module_operand_ctrl.sv
// Directed bench for module_operand_ctrl with TIMEOUT=16; the outputs are packed into
// one vector and compared against hand-computed expectations after each clock.
module tb_module_operand_ctrl;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   module_operand_ctrl_if #(.N(4)) bus ();

   module_operand_ctrl #(.N(4), .TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {tens, units, a_tens, a_units, b_tens, b_units, clr, start, disp[1:0], busy, err}
   function automatic logic [17:0] obs();
      return {bus.tens_d, bus.units_d, bus.a_tens_en, bus.a_units_en, bus.b_tens_en,
              bus.b_units_en, bus.clr_regs, bus.op_start, bus.disp_sel, bus.busy, bus.err};
   endfunction

   function automatic logic [17:0] ex(input int t, input int u, input int a, input int b,
                                      input int c, input int s, input int d, input int bz,
                                      input int e);
      logic [3:0] t4, u4;
      logic [1:0] d2;
      t4 = 4'(t);
      u4 = 4'(u);
      d2 = 2'(d);
      return {t4, u4, 1'(a), 1'(a), 1'(b), 1'(b), 1'(c), 1'(s), d2, 1'(bz), 1'(e)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] code);
      bus.key_valid = 1'b1;
      bus.key_code  = code;
      step();
      bus.key_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [17:0] e;
      rst = 1'b0;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      bus.res_done  = 1'b0;
      step();
      step();
      e = ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL reset: got %h exp %h", obs(), e); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_ignored();
      logic [17:0] e;
      e = ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
      press(4'hE);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL ignored_key: got %h exp %h", obs(), e); end
      bus.res_done = 1'b1;
      step();
      bus.res_done = 1'b0;
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL ignored_res_done: got %h exp %h", obs(), e); end
   endtask

   task automatic test_entry_a();
      logic [3:0]  keys [6];
      logic [17:0] exps [6];
      keys = '{4'h4, 4'h7, 4'h3, 4'hA, 4'hA, 4'h9};
      exps = '{ex(0, 4, 1, 0, 0, 0, 0, 0, 0), ex(4, 7, 1, 0, 0, 0, 0, 0, 0),
               ex(4, 7, 0, 0, 0, 0, 0, 0, 0), ex(4, 7, 0, 0, 0, 0, 1, 0, 0),
               ex(4, 7, 0, 0, 0, 0, 1, 0, 0), ex(0, 9, 0, 1, 0, 0, 1, 0, 0)};
      for (int i = 0; i < 6; i++) begin
         press(keys[i]);
         n_checks++;
         if (obs() !== exps[i]) begin
            n_fail++;
            $display("FAIL entry[%0d]: got %h exp %h", i, obs(), exps[i]);
         end
      end
   endtask

   task automatic test_compute();
      logic [17:0] e;
      int busy_cycles;
      int starts;
      press(4'hA);
      e = ex(0, 9, 0, 0, 0, 1, 1, 1, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL start: got %h exp %h", obs(), e); end
      busy_cycles = int'(bus.busy);
      starts      = int'(bus.op_start);
      e = ex(0, 9, 0, 0, 0, 0, 1, 1, 0);
      for (int i = 1; i <= 5; i++) begin
         bus.key_valid = (i == 3);
         bus.key_code  = 4'h5;
         step();
         bus.key_valid = 1'b0;
         busy_cycles += int'(bus.busy);
         starts      += int'(bus.op_start);
         n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL wait[%0d]: got %h exp %h", i, obs(), e); end
      end
      bus.res_done = 1'b1;
      step();
      bus.res_done = 1'b0;
      e = ex(0, 9, 0, 0, 0, 0, 2, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL show: got %h exp %h", obs(), e); end
      n_checks++;
      if (busy_cycles !== 6) begin n_fail++; $display("FAIL busy_len: got %0d exp 6", busy_cycles); end
      n_checks++;
      if (starts !== 1) begin n_fail++; $display("FAIL start_count: got %0d exp 1", starts); end
      press(4'h3);
      e = ex(0, 9, 0, 0, 1, 0, 0, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL show_consume: got %h exp %h", obs(), e); end
      press(4'h3);
      e = ex(0, 3, 1, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL reentry: got %h exp %h", obs(), e); end
   endtask

   task automatic test_timeout();
      logic [17:0] e;
      press(4'hA);
      press(4'h2);
      e = ex(0, 2, 0, 1, 0, 0, 1, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL to_b_entry: got %h exp %h", obs(), e); end
      press(4'hA);
      e = ex(0, 2, 0, 0, 0, 0, 1, 1, 0);
      for (int i = 1; i <= 15; i++) begin
         step();
         n_checks++;
         if (obs() !== e) begin n_fail++; $display("FAIL to_wait[%0d]: got %h exp %h", i, obs(), e); end
      end
      step();
      e = ex(0, 2, 0, 0, 0, 0, 3, 0, 1);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL to_err: got %h exp %h", obs(), e); end
      bus.res_done = 1'b1;
      step();
      bus.res_done = 1'b0;
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL err_sticky: got %h exp %h", obs(), e); end
      press(4'hA);
      e = ex(0, 2, 0, 0, 1, 0, 0, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL err_consume: got %h exp %h", obs(), e); end
   endtask

   task automatic test_done_at_timeout();
      logic [17:0] e;
      press(4'h1);
      press(4'hA);
      press(4'h2);
      press(4'hA);
      for (int i = 1; i <= 15; i++) step();
      bus.res_done = 1'b1;
      step();
      bus.res_done = 1'b0;
      e = ex(0, 2, 0, 0, 0, 0, 2, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL done_wins: got %h exp %h", obs(), e); end
      press(4'hC);
      e = ex(0, 2, 0, 0, 1, 0, 0, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL clear_show: got %h exp %h", obs(), e); end
   endtask

   task automatic test_clear();
      logic [17:0] e;
      press(4'h1);
      press(4'hA);
      press(4'h2);
      press(4'hA);
      step();
      step();
      step();
      press(4'hC);
      e = ex(0, 2, 0, 0, 1, 0, 0, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL clear_wait: got %h exp %h", obs(), e); end
      step();
      e = ex(0, 2, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL clear_pulse_len: got %h exp %h", obs(), e); end
      press(4'h5);
      press(4'hA);
      press(4'h6);
      press(4'hC);
      e = ex(0, 6, 0, 0, 1, 0, 0, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL clear_entry_b: got %h exp %h", obs(), e); end
      press(4'h8);
      e = ex(0, 8, 1, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL after_clear: got %h exp %h", obs(), e); end
   endtask

   task automatic test_back_to_back();
      logic [17:0] e;
      press(4'hC);
      bus.key_valid = 1'b1;
      bus.key_code  = 4'h1;
      step();
      e = ex(0, 1, 1, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL b2b_first: got %h exp %h", obs(), e); end
      bus.key_code = 4'h2;
      step();
      bus.key_valid = 1'b0;
      e = ex(1, 2, 1, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL b2b_second: got %h exp %h", obs(), e); end
      step();
      e = ex(1, 2, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL b2b_idle: got %h exp %h", obs(), e); end
   endtask

   task automatic test_async_reset();
      logic [17:0] e;
      press(4'hA);
      press(4'h3);
      press(4'hA);
      step();
      step();
      #2;
      rst = 1'b0;
      #1;
      e = ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL async_reset: got %h exp %h", obs(), e); end
      step();
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL reset_hold: got %h exp %h", obs(), e); end
      rst = 1'b1;
      step();
      n_checks++;
      if (obs() !== e) begin n_fail++; $display("FAIL reset_release: got %h exp %h", obs(), e); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_ignored();
      test_entry_a();
      test_compute();
      test_timeout();
      test_done_at_timeout();
      test_clear();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
